// File: rtl/mem_stream_reader.sv
// Read-side sequencer for one block-RAM port: issues credit-limited reads, absorbs the
// one-cycle registered read latency through a 4-entry FIFO and streams words out on valid/ready.
module mem_stream_reader #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             start,
    input  logic [AW-1:0]    base_addr,
    input  logic [AW:0]      length,
    output logic             busy,
    output logic             done,
    output logic [AW-1:0]    mem_address,
    output logic             mem_wren,
    input  logic [WIDTH-1:0] mem_q,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_nx_s;
    logic [AW-1:0]     addr_r;
    logic [AW:0]       issue_cnt_r;
    logic [AW:0]       out_cnt_r;
    logic              in_flight_r;
    logic [WIDTH-1:0]  fifo_mem_r [4];
    logic [1:0]        wr_ptr_r;
    logic [1:0]        rd_ptr_r;
    logic [2:0]        fifo_count_r;
    logic              issue_s;
    logic              push_s;
    logic              pop_s;
    logic              accept_s;

    // Credit check counts the word still in the RAM output register so the FIFO can never overflow.
    assign issue_s  = (state_r == S_READ) && (issue_cnt_r != {(AW+1){1'b0}})
                      && (({2'b00, in_flight_r} + fifo_count_r) < 3'd4);
    assign push_s   = in_flight_r;
    assign pop_s    = dout_valid && dout_ready;
    assign accept_s = (state_r == S_IDLE) && start;

    // addr_r stops on the last issued address so mem_address holds through DRAIN.
    assign mem_address = addr_r;
    assign mem_wren    = 1'b0;
    assign dout        = fifo_mem_r[rd_ptr_r];
    assign dout_valid  = (fifo_count_r != 3'd0);

    // State register.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_nx_s = (length != {(AW+1){1'b0}}) ? S_READ : S_DONE;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_READ: begin
                if (issue_s && (issue_cnt_r == {{AW{1'b0}}, 1'b1})) begin
                    state_nx_s = S_DRAIN;
                end else begin
                    state_nx_s = S_READ;
                end
            end
            S_DRAIN: begin
                if (pop_s && (out_cnt_r == {{AW{1'b0}}, 1'b1})) begin
                    state_nx_s = S_DONE;
                end else begin
                    state_nx_s = S_DRAIN;
                end
            end
            S_DONE:  state_nx_s = S_IDLE;
            default: state_nx_s = S_IDLE;
        endcase
    end

    // Status outputs decoded from the state register.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_r)
            S_IDLE:  begin busy = 1'b0; done = 1'b0; end
            S_READ:  begin busy = 1'b1; done = 1'b0; end
            S_DRAIN: begin busy = 1'b1; done = 1'b0; end
            S_DONE:  begin busy = 1'b1; done = 1'b1; end
            default: begin busy = 1'b0; done = 1'b0; end
        endcase
    end

    // Address and word counters.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            addr_r      <= {AW{1'b0}};
            issue_cnt_r <= {(AW+1){1'b0}};
            out_cnt_r   <= {(AW+1){1'b0}};
            in_flight_r <= 1'b0;
        end else begin
            in_flight_r <= issue_s;
            if (accept_s) begin
                addr_r      <= base_addr;
                issue_cnt_r <= length;
                out_cnt_r   <= length;
            end else begin
                if (issue_s) begin
                    issue_cnt_r <= issue_cnt_r - {{AW{1'b0}}, 1'b1};
                    if (issue_cnt_r != {{AW{1'b0}}, 1'b1}) begin
                        addr_r <= (addr_r == AW'(DEPTH-1)) ? {AW{1'b0}} : addr_r + {{(AW-1){1'b0}}, 1'b1};
                    end else begin
                        addr_r <= addr_r;
                    end
                end else begin
                    issue_cnt_r <= issue_cnt_r;
                end
                if (pop_s) begin
                    out_cnt_r <= out_cnt_r - {{AW{1'b0}}, 1'b1};
                end else begin
                    out_cnt_r <= out_cnt_r;
                end
            end
        end
    end

    // Output FIFO; push lands in a free slot so a simultaneous pop never disturbs the head.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                fifo_mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r     <= 2'd0;
            rd_ptr_r     <= 2'd0;
            fifo_count_r <= 3'd0;
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= mem_q;
                wr_ptr_r             <= wr_ptr_r + 2'd1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 2'd1;
            end
            case ({push_s, pop_s})
                2'b10:   fifo_count_r <= fifo_count_r + 3'd1;
                2'b01:   fifo_count_r <= fifo_count_r - 3'd1;
                default: fifo_count_r <= fifo_count_r;
            endcase
        end
    end

endmodule

// File: doc/mem_stream_reader.md
# mem_stream_reader

Read-side sequencer for a single port of the dual-ported block RAM. Given a base address and a word count, it issues back-to-back reads, absorbs the RAM's one-cycle registered read latency, and presents the words in order on a valid/ready stream with full backpressure. Arithmetic cores use it to stream polynomial or vector coefficients out of RAM, one word per cycle when the consumer never stalls.

## Interface
- WIDTH, 8, data word width; must match the attached RAM.
- DEPTH, 64, RAM depth in words; AW = `CLOG2(DEPTH).
- clock  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_addr  in  AW  first word address; latched on an accepted start.
- length  in  AW+1  number of words (0..2*DEPTH-1); latched on an accepted start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last word handshakes.
- mem_address  out  AW  RAM read address.
- mem_wren  out  1  constant 0.
- mem_q  in  WIDTH  RAM registered read data.
- dout  out  WIDTH  stream data; valid only while dout_valid is high.
- dout_valid  out  1  stream valid.
- dout_ready  in  1  consumer ready; handshake when dout_valid && dout_ready.

## Operation
- States: IDLE, READ, DRAIN, DONE.
- IDLE: start=1 latches base_addr into addr_r and length into issue_cnt and out_cnt. If length≠0, go to READ; if length=0, go to DONE.
- READ: mem_address=addr_r. A read issues in a cycle when issue_cnt≠0 and in_flight+fifo_count<4. A read increments addr_r, wrapping DEPTH-1→0, and decrements issue_cnt. When the last read issues, go to DRAIN.
- Read pipeline: a read issued in cycle N produces mem_q in cycle N+1. That word is written into a 4-entry FIFO at the end of cycle N+1. in_flight counts reads issued whose data is not yet written, so the credit limit (in_flight+fifo_count ≤ 4) prevents FIFO overflow.
- dout/dout_valid come from the FIFO head. Each handshake pops one entry and decrements out_cnt.
- A FIFO push and pop in the same cycle leave fifo_count unchanged. The order is push-before-pop, so a word written at full count is never lost.
- DRAIN: no reads issue, mem_address holds its last value. When out_cnt reaches 0 through a handshake, go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE. start is ignored in DONE.
- start while busy=1 is ignored; the latched parameters do not change.
- dout_ready with dout_valid=0 has no effect. dout_valid never drops without a handshake, and dout stays stable while stalled.
- mem_address in IDLE/DONE holds its last value; it is don't-care there because no read is issued.

## Timing
- Reset (async, immediate) sets: state=IDLE, busy=0, done=0, dout_valid=0, dout=0, mem_address=0, mem_wren=0, FIFO empty, all counters 0.
- Reset mid-operation aborts the transfer and drops in-flight data. There is no done pulse, and the first post-reset start behaves normally.
- start accepted in cycle 0:
  - busy=1 from cycle 1.
  - First read issues in cycle 1.
  - First dout_valid is in cycle 3.
- With dout_ready held at 1, words handshake in cycles 3..3+L-1, done=1 in cycle 3+L, and busy=0 from cycle 4+L. Sustained rate is 1 word/cycle.
- length=0: done=1 in cycle 1, no reads issue, dout_valid stays 0.
- The earliest next start is the cycle in which busy=0.
- Stall: the FIFO fills to 4 and issue pauses. When ready returns, output resumes the next cycle with no bubble, and issue resumes the same cycle a slot frees.

## Test plan
- RAM[i]=i, base=0, length=8, ready=1 → dout 0..7 in cycles 3..10, done in cycle 11, mem_wren always 0.
- base=DEPTH-3, length=6, ready=1 → dout DEPTH-3, DEPTH-2, DEPTH-1, 0, 1, 2 (address wrap).
- length=0 → done in cycle 1, no dout_valid, busy high only in cycle 1.
- length=20 with ready toggling randomly, including a 10-cycle stall → all 20 words in order with no duplicates or drops, FIFO count ≤4, dout stable whenever valid&&!ready.
- start pulsed again mid-transfer and in the DONE cycle → ignored, output unchanged; a start in the first cycle with busy=0 is accepted.
- rst asserted at the 5th word of 16 → all outputs at reset values immediately, no done; a new transfer with base=4, length=3 then yields RAM[4..6].
